// File: rtl/ucall_stack_if.sv
// ucall_stack_if -- bus between the microsequencer and the microcode call/return stack.
//   master (sequencer side): drives call, ret, addrIN and diagSEL.
//                            Receives addrOUT, depth, overflow, underflow and diagOUT.
//   slave  (stack side):     the mirror image of master.
interface ucall_stack_if #(
   parameter int WIDTH = 12,
   parameter int PTRW  = 4
);
   logic             call;       // push request (CALL or page fail)
   logic             ret;        // pop request (return dispatch)
   logic [WIDTH-1:0] addrIN;     // address to push
   logic [WIDTH-1:0] addrOUT;    // top of stack / return address
   logic [PTRW:0]    depth;      // valid entries, 0..DEPTH
   logic             overflow;   // sticky: push while full
   logic             underflow;  // sticky: pop while empty
   logic [PTRW-1:0]  diagSEL;    // diagnostic entry select, 0 = top
   logic [WIDTH-1:0] diagOUT;    // selected entry

   modport master (
      output call, ret, addrIN, diagSEL,
      input  addrOUT, depth, overflow, underflow, diagOUT
   );
   modport slave (
      input  call, ret, addrIN, diagSEL,
      output addrOUT, depth, overflow, underflow, diagOUT
   );
endinterface

// File: rtl/ucall_stack.sv
// ucall_stack -- microcode call/return stack for the KS10 microsequencer.
// It uses a ring of DEPTH x WIDTH registers. A push writes mem[ptr] and advances ptr.
// The top of stack is mem[ptr-1]. When the stack is full, a push overwrites the oldest
// entry.
// Ports:
//   clk, rst  - clock and synchronous active-high reset. Reset overrides clken.
//   clken     - clock enable. All state holds while it is low.
//   bus       - ucall_stack_if.slave. It carries call/ret/addrIN in, addrOUT/depth/flags out,
//               and the diagSEL -> diagOUT read port.
// All outputs are combinational from registered state. No path exists from call or ret to
// any output.
module ucall_stack #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16,
   parameter int PTRW  = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clken,
   ucall_stack_if.slave  bus
);
   localparam logic [PTRW:0]   FULL = (PTRW+1)'(DEPTH);
   localparam logic [PTRW-1:0] ONE  = PTRW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTRW-1:0]  ptr;
   logic [PTRW:0]    cnt;
   logic             ovf, unf;

   logic [PTRW-1:0]  topIdx, diagIdx;
   logic             isEmpty, isFull;

   assign topIdx  = ptr - ONE;
   assign diagIdx = ptr - ONE - bus.diagSEL;
   assign isEmpty = (cnt == '0);
   assign isFull  = (cnt == FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         ptr <= '0;
         cnt <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else if (clken) begin
         unique case ({bus.call, bus.ret})
            2'b10: begin
               mem[ptr] <= bus.addrIN;
               ptr      <= ptr + ONE;
               if (isFull) ovf <= 1'b1;   // oldest entry lost, count saturates
               else        cnt <= cnt + 1'b1;
            end
            2'b01: begin
               if (isEmpty) unf <= 1'b1;
               else begin
                  ptr <= ptr - ONE;       // contents left in place
                  cnt <= cnt - 1'b1;
               end
            end
            2'b11: begin
               // A page fail that coincides with a return replaces the top entry.
               // On an empty stack this degenerates into a push and flags underflow.
               if (isEmpty) begin
                  mem[ptr] <= bus.addrIN;
                  ptr      <= ptr + ONE;
                  cnt      <= (PTRW+1)'(1);
                  unf      <= 1'b1;
               end else begin
                  mem[topIdx] <= bus.addrIN;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.addrOUT   = isEmpty ? '0 : mem[topIdx];
   assign bus.diagOUT   = ({1'b0, bus.diagSEL} < cnt) ? mem[diagIdx] : '0;
   assign bus.depth     = cnt;
   assign bus.overflow  = ovf;
   assign bus.underflow = unf;
endmodule

// File: doc/ucall_stack.md
# ucall_stack

Microcode call/return stack for the KS10 microsequencer. Sits directly downstream of the microsequencer address mux and feeds the return-dispatch input of the dispatch mux. It pushes the control-ROM address on a microcode call or page fail and presents the top entry as the return address. It also tracks stack depth, flags overflow and underflow for diagnostics, and provides a read port into any live entry.

## Interface

Parameters:
- `WIDTH`, 12, control-ROM address width.
- `DEPTH`, 16, number of stack entries. Must be a power of two, ≥ 2.
- `PTRW`, log2(`DEPTH`) = 4, pointer and diagnostic-select width.

Ports:
- `clk`: input, 1, clock.
- `rst`: input, 1, reset. Synchronous and active-high.
- `clken`: input, 1, clock enable. State changes only when high.
- `call`: input, 1, push request. Driven by microcode CALL or by page fail.
- `ret`: input, 1, pop request. Driven by return dispatch.
- `addrIN`: input, `WIDTH`, address to push.
- `addrOUT`: output, `WIDTH`, current top-of-stack (return address).
- `depth`: output, `PTRW`+1, number of valid entries, 0..`DEPTH`.
- `overflow`: output, 1, sticky. A push occurred while full.
- `underflow`: output, 1, sticky. A pop occurred while empty.
- `diagSEL`: input, `PTRW`, diagnostic entry select. 0 = top.
- `diagOUT`: output, `WIDTH`, selected entry.

## Operation

- Storage is a ring of `DEPTH` × `WIDTH` registers, with write pointer `ptr` (`PTRW` bits, wraps) and occupancy `cnt` (0..`DEPTH`).
- Top entry = `mem[ptr-1]` (modulo `DEPTH`).
- All updates occur on the rising edge of `clk` with `clken`=1. With `clken`=0, all state holds regardless of `call` or `ret`.
- `rst`=1 takes priority over `clken`. It clears every `mem` entry, `ptr`, `cnt`, `overflow` and `underflow`.
- Push (`call`=1, `ret`=0):
  - `mem[ptr]` ← `addrIN`; `ptr` ← `ptr`+1.
  - If `cnt` < `DEPTH`, `cnt` increments.
  - If `cnt` = `DEPTH`, the oldest entry is overwritten, `cnt` stays at `DEPTH`, and `overflow` ← 1.
- Pop (`call`=0, `ret`=1):
  - If `cnt` > 0: `ptr` ← `ptr`−1 and `cnt` decrements. Entry contents are not cleared.
  - If `cnt` = 0: `ptr` and `cnt` are unchanged and `underflow` ← 1.
- Simultaneous (`call`=1, `ret`=1; occurs when page fail coincides with a return dispatch):
  - If `cnt` > 0: replace top. `mem[ptr-1]` ← `addrIN`; `ptr` and `cnt` are unchanged.
  - If `cnt` = 0: behave as a push (`cnt` ← 1) and set `underflow` ← 1.
- `addrOUT` = `mem[ptr-1]` when `cnt` > 0, else all zeros.
- `diagOUT` = `mem[ptr-1-diagSEL]` when `diagSEL` < `cnt`, else all zeros.
- `depth` = `cnt`.
- `overflow` and `underflow` clear only on `rst`.

## Timing

- Reset values: `addrOUT`=0, `depth`=0, `overflow`=0, `underflow`=0, `diagOUT`=0.
- `addrOUT`, `depth` and `diagOUT` are combinational from registered state. They show the effect of a push or pop in the cycle after the enabling edge, i.e. 1-cycle latency.
- `addrOUT` is valid in the same cycle `ret` is asserted. That is the value consumed by return dispatch; the pop takes effect at the end of that cycle.
- The pushed `addrIN` is sampled at the `clken` edge. The producer holds it stable for the cycle.
- No combinational path from `call` or `ret` to any output.
- `rst` asserted mid-sequence discards all entries at that edge. The first enabled edge after `rst` negates sees an empty stack.

## Test plan

- **Reset:** hold `rst` for 3 cycles with random `call`/`ret`/`clken` → `addrOUT`=0, `depth`=0, both flags 0; `diagOUT`=0 for all `diagSEL`.
- **LIFO order:** push 0o0100, 0o0200, 0o0300 → `depth`=3, `addrOUT`=0o0300, `diagOUT`(`diagSEL`=2)=0o0100. Then pop 3 times → `addrOUT` reads 0o0200, 0o0100, 0 in turn; `depth`=0; `underflow`=0.
- **Overflow wrap:** `DEPTH`=16; push 0o0001..0o0021 (17 values) → `depth`=16, `overflow`=1, `addrOUT`=0o0021. Then 16 pops return 0o0021 down to 0o0002 → `depth`=0.
- **Underflow:** pop on empty → `depth`=0, `addrOUT`=0, `underflow`=1, and it stays 1 after a subsequent push of 0o3777.
- **Simultaneous:** push 0o0100, 0o0200; then `call`=`ret`=1 with `addrIN`=0o3777 → `depth`=2, `addrOUT`=0o3777, `diagOUT`(1)=0o0100. Repeat on an empty stack → `depth`=1, `addrOUT`=0o3777, `underflow`=1.
- **Clock enable:** `clken`=0 while pulsing `call` with 0o0555 and `ret` for 5 cycles → all outputs unchanged. Assert `clken` with `call` → `addrOUT`=0o0555 the next cycle.
